exc_irq_ctrl: RTL

- Parametrised exception/interrupt sequencer; successor to the hard-wired overflow/op404/div-zero exception states in the multicycle control unit.
- Adds NUM_IRQ maskable external interrupt lines, a registered EPC/cause, and return-from-exception support.
- Sits beside the control unit: receives synchronous fault pulses and the instruction-boundary strobe, and drives EPC/cause writes and the PC vector select.

---
 rtl/exc_pkg.sv | 34 +++
 rtl/irq_prio_enc.sv | 30 +++
 rtl/exc_irq_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared constants for the exception/interrupt sequencer:
//   - cause codes written to the cause register
//   - FSM state encodings (plain localparams so legacy tools and waveform
//     viewers see stable 3-bit values)
//   - default handler vector address
//   - fault_cause(): fixed-priority selection among the synchronous faults
// No ports (package).
// ---------------------------------------------------------------------------
package exc_pkg;

  localparam int CAUSE_OVF      = 0;
  localparam int CAUSE_DIV0     = 1;
  localparam int CAUSE_OP404    = 2;
  localparam int CAUSE_IRQ_BASE = 4;   // IRQ k reports CAUSE_IRQ_BASE + k

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAVE    = 3'd1;
  localparam logic [2:0] ST_VECTOR  = 3'd2;
  localparam logic [2:0] ST_HANDLER = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [31:0] DEFAULT_VEC_ADDR = 32'h0000_00FF;

  // Illegal opcode outranks overflow, which outranks divide-by-zero.
  // Only meaningful when at least one fault is present.
  function automatic int fault_cause(input logic op404, input logic ovf);
    if (op404)    return CAUSE_OP404;
    else if (ovf) return CAUSE_OVF;
    else          return CAUSE_DIV0;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-wins priority encoder for the pending interrupt vector.
// Ports:
//   i_vec   [N-1:0]      request vector
//   o_idx   [IDX_W-1:0]  index of the lowest set bit (0 when none set)
//   o_valid              at least one request set
// ---------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    o_idx = '0;
    // Scan high to low so the last (lowest) set bit overwrites the rest.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/exc_irq_ctrl.sv
// ---------------------------------------------------------------------------
// exc_irq_ctrl
// Exception / interrupt sequencer sitting beside the multicycle control unit.
// A synchronous fault (any cycle in IDLE) or an enabled pending interrupt (at
// an instruction boundary) is accepted, the PC and cause are latched, then the
// sequence SAVE (epc_wr) -> VECTOR (exc_take) -> HANDLER runs until rfe.
//
// Build option: define EXC_DOUBLE_FAULT_EN to halt on a fault raised while
// already in the handler; otherwise such a fault is taken like any other.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_instr_boundary            fetch point, safe to take an interrupt
//   i_sync_ovf/div0/op404       synchronous fault pulses
//   i_irq[NUM_IRQ]              level interrupts
//   i_mask_wr, i_mask_din       interrupt enable register write
//   i_pc_in[DATA_W]             PC to save
//   i_rfe                       return from exception
//   o_stall                     hold the control unit
//   o_epc_wr, o_epc, o_cause    EPC/cause write strobe and registers
//   o_exc_take, o_pc_vec        redirect strobe and vector address
//   o_in_handler                handler active
//   o_irq_pend                  registered irq & mask
//   o_halt                      double fault halt
// ---------------------------------------------------------------------------
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_IRQ  = 4,
  parameter int                CAUSE_W  = 4,
  parameter logic [DATA_W-1:0] VEC_ADDR = DATA_W'(DEFAULT_VEC_ADDR)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_instr_boundary,
  input  logic               i_sync_ovf,
  input  logic               i_sync_div0,
  input  logic               i_sync_op404,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_mask_wr,
  input  logic [NUM_IRQ-1:0] i_mask_din,
  input  logic [DATA_W-1:0]  i_pc_in,
  input  logic               i_rfe,
  output logic               o_stall,
  output logic               o_epc_wr,
  output logic [DATA_W-1:0]  o_epc,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_exc_take,
  output logic [DATA_W-1:0]  o_pc_vec,
  output logic               o_in_handler,
  output logic [NUM_IRQ-1:0] o_irq_pend,
  output logic               o_halt
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  if (NUM_IRQ < 1 || NUM_IRQ > 8 || (CAUSE_IRQ_BASE + NUM_IRQ) > (1 << CAUSE_W))
  begin : g_bad_cfg
    $error("exc_irq_ctrl: NUM_IRQ must be 1..8 and fit in the cause register");
  end

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [DATA_W-1:0]  r_epc;
  logic [CAUSE_W-1:0] r_cause;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_irq_pend;

  logic               w_fault;
  logic               w_capture;
  logic [CAUSE_W-1:0] w_fault_cause;
  logic [CAUSE_W-1:0] w_irq_cause;
  logic [IDX_W-1:0]   w_irq_idx;
  logic               w_irq_valid;

  irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
    .i_vec  (r_irq_pend),
    .o_idx  (w_irq_idx),
    .o_valid(w_irq_valid)
  );

  assign w_fault       = i_sync_op404 | i_sync_ovf | i_sync_div0;
  assign w_fault_cause = CAUSE_W'(fault_cause(i_sync_op404, i_sync_ovf));
  assign w_irq_cause   = CAUSE_W'(CAUSE_IRQ_BASE) + CAUSE_W'(w_irq_idx);

  // w_capture marks the edge at which PC and cause are latched; a fault
  // always beats an interrupt that is pending in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fault || (i_instr_boundary && w_irq_valid)) begin
          w_state_nxt = ST_SAVE;
          w_capture   = 1'b1;
        end
      end
      ST_SAVE:   w_state_nxt = ST_VECTOR;
      ST_VECTOR: w_state_nxt = ST_HANDLER;
      ST_HANDLER: begin
        // Interrupts are not nested; only a fault can leave early.
        if (w_fault) begin
`ifdef EXC_DOUBLE_FAULT_EN
          w_state_nxt = ST_HALT;
`else
          w_state_nxt = ST_SAVE;
          w_capture   = 1'b1;
`endif
        end else if (i_rfe) begin
          w_state_nxt = ST_IDLE;
        end
      end
`ifdef EXC_DOUBLE_FAULT_EN
      ST_HALT:   w_state_nxt = ST_HALT;
`endif
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_epc      <= '0;
      r_cause    <= '0;
      r_mask     <= '0;
      r_irq_pend <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Uses the mask already in force; a new mask shows up one cycle later.
      r_irq_pend <= i_irq & r_mask;
      if (i_mask_wr) r_mask <= i_mask_din;
      if (w_capture) begin
        r_epc   <= i_pc_in;
        r_cause <= w_fault ? w_fault_cause : w_irq_cause;
      end
    end
  end

  assign o_epc_wr     = (r_state == ST_SAVE);
  assign o_exc_take   = (r_state == ST_VECTOR);
  assign o_in_handler = (r_state == ST_HANDLER);
  assign o_stall      = (r_state == ST_SAVE) || (r_state == ST_VECTOR) ||
                        (r_state == ST_HALT);
`ifdef EXC_DOUBLE_FAULT_EN
  assign o_halt       = (r_state == ST_HALT);
`else
  assign o_halt       = 1'b0;
`endif
  assign o_epc        = r_epc;
  assign o_cause      = r_cause;
  assign o_irq_pend   = r_irq_pend;
  assign o_pc_vec     = VEC_ADDR;

endmodule
